// File: rtl/serv_ext_shreg.sv
// Result shift register for the extension scheduler.
// Holds the 32-bit result word. Loading it clears the shift count.
// Each enabled shift moves the word right by one bit, zero fill.
// o_done rises after the 32nd shift and then holds.
module serv_ext_shreg #(
    parameter RESET_STRATEGY = "MINI"
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_d,
    input  logic        i_shift,
    output logic [31:0] o_q,
    output logic        o_done
);

    localparam bit RST_DP = (RESET_STRATEGY != "NONE");

    logic [31:0] q_q,    q_d;
    logic [4:0]  cnt_q,  cnt_d;
    logic        done_q, done_d;

    // Next-state logic: load has priority, and shifting stops once all 32 bits are out.
    always_comb begin
        // NOTE: every _d gets a default first, so no path can hold a value combinationally (no latch).
        q_d    = q_q;
        cnt_d  = cnt_q;
        done_d = done_q;
        if (i_load) begin
            q_d    = i_d;
            cnt_d  = 5'd0;
            done_d = 1'b0;
        end else if (i_shift && !done_q) begin
            q_d = {1'b0, q_q[31:1]};
            if (cnt_q == 5'd31) begin
                done_d = 1'b1;              // count saturates at 31 and never wraps
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    // Register update. Under the "NONE" strategy this datapath is left unreset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (RST_DP && i_rst) begin
            q_q    <= 32'd0;
            cnt_q  <= 5'd0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign o_q    = q_q;
    assign o_done = done_q;

endmodule

// File: rtl/serv_ext_sched.sv
// Extension-slot scheduler. It arbitrates between the MDU and the AVA unit and
// forwards registered operands to the granted unit. It then waits for that
// unit's ready, with an optional timeout. The captured result is strobed to the
// core and shifted out LSB first while the core bit counter runs.
module serv_ext_sched #(
    parameter     RESET_STRATEGY = "MINI",
    parameter int MDU            = 1,
    parameter int AVA            = 1,
    parameter int TIMEOUT        = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mdu_req,
    input  logic        i_ava_req,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output logic        o_mdu_valid,
    output logic        o_ava_valid,
    output logic [2:0]  o_ext_funct3,
    output logic [31:0] o_ext_rs1,
    output logic [31:0] o_ext_rs2,
    input  logic        i_mdu_ready,
    input  logic [31:0] i_mdu_rd,
    input  logic        i_ava_ready,
    input  logic [31:0] i_ava_rd,
    output logic        o_ready,
    input  logic        i_cnt_en,
    output logic        o_rd,
    output logic        o_busy,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam bit       RST_DP = (RESET_STRATEGY != "NONE");
    localparam bit       TO_EN  = (TIMEOUT != 0);
    localparam bit [7:0] TO_LIM = 8'(TIMEOUT);

    state_t      state_q,     state_d;
    logic        gnt_ava_q,   gnt_ava_d;    // granted unit: 0 = MDU, 1 = AVA
    logic        prio_ava_q,  prio_ava_d;   // round-robin winner when both request
    logic [7:0]  tmr_q,       tmr_d;        // WAIT cycle number, saturating
    logic        timeout_q,   timeout_d;
    logic        mdu_valid_q, mdu_valid_d;
    logic        ava_valid_q, ava_valid_d;
    logic        ready_q,     ready_d;
    logic        busy_q,      busy_d;
    logic        drain_q,     drain_d;

    logic [2:0]  funct3_q;
    logic [31:0] rs1_q, rs2_q;

    logic        eff_mdu, eff_ava;
    logic        gnt_req, gnt_rdy;
    logic [31:0] gnt_rd;
    logic        grant;
    logic        sh_load;
    logic [31:0] sh_d;
    logic        sh_shift;
    logic [31:0] sh_q;
    logic        sh_done;

    assign eff_mdu  = (MDU != 0) && i_mdu_req;
    assign eff_ava  = (AVA != 0) && i_ava_req;
    assign gnt_req  = gnt_ava_q ? eff_ava     : eff_mdu;
    assign gnt_rdy  = gnt_ava_q ? i_ava_ready : i_mdu_ready;
    assign gnt_rd   = gnt_ava_q ? i_ava_rd    : i_mdu_rd;
    assign sh_shift = (state_q == DRAIN) && i_cnt_en;

    // FSM next state, arbitration, timeout tracking and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        gnt_ava_d  = gnt_ava_q;
        prio_ava_d = prio_ava_q;
        tmr_d      = tmr_q;
        timeout_d  = timeout_q;
        grant      = 1'b0;
        sh_load    = 1'b0;
        sh_d       = 32'd0;
        unique case (state_q)
            IDLE: begin
                if (eff_mdu || eff_ava) begin
                    grant      = 1'b1;
                    gnt_ava_d  = eff_ava && (!eff_mdu || prio_ava_q);
                    prio_ava_d = !gnt_ava_d;
                    timeout_d  = 1'b0;
                    tmr_d      = 8'd1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (!gnt_req) begin
                    state_d = IDLE;             // core withdrew the request: silent abort
                end else if (gnt_rdy) begin
                    sh_load = 1'b1;             // ready beats a simultaneous expiry
                    sh_d    = gnt_rd;
                    state_d = RESP;
                end else if (TO_EN && (tmr_q == TO_LIM)) begin
                    sh_load   = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else if (tmr_q != 8'hFF) begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            RESP: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (sh_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        mdu_valid_d = (state_d == WAIT) && !gnt_ava_d;
        ava_valid_d = (state_d == WAIT) &&  gnt_ava_d;
        ready_d     = (state_d == RESP);
        busy_d      = (state_d != IDLE);
        drain_d     = (state_d == DRAIN);
    end

    // Control state and registered outputs. These are always reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            gnt_ava_q   <= 1'b0;
            prio_ava_q  <= 1'b0;
            tmr_q       <= 8'd0;
            timeout_q   <= 1'b0;
            mdu_valid_q <= 1'b0;
            ava_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            drain_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_ava_q   <= gnt_ava_d;
            prio_ava_q  <= prio_ava_d;
            tmr_q       <= tmr_d;
            timeout_q   <= timeout_d;
            mdu_valid_q <= mdu_valid_d;
            ava_valid_q <= ava_valid_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            drain_q     <= drain_d;
        end
    end

    // Operand registers. They capture on grant and are reset only when the strategy asks for it.
    always_ff @(posedge i_clk) begin
        if (RST_DP && i_rst) begin
            funct3_q <= 3'd0;
            rs1_q    <= 32'd0;
            rs2_q    <= 32'd0;
        end else if (grant) begin
            funct3_q <= i_funct3;
            rs1_q    <= i_rs1;
            rs2_q    <= i_rs2;
        end
    end

    serv_ext_shreg #(
        .RESET_STRATEGY (RESET_STRATEGY)
    ) u_shreg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (sh_load),
        .i_d     (sh_d),
        .i_shift (sh_shift),
        .o_q     (sh_q),
        .o_done  (sh_done)
    );

    assign o_mdu_valid  = mdu_valid_q;
    assign o_ava_valid  = ava_valid_q;
    assign o_ext_funct3 = funct3_q;
    assign o_ext_rs1    = rs1_q;
    assign o_ext_rs2    = rs2_q;
    assign o_ready      = ready_q;
    assign o_busy       = busy_q;
    assign o_timeout    = timeout_q;
    assign o_rd         = drain_q && sh_q[0];

endmodule

// File: tb/tb_serv_ext_sched.sv
// Self-checking bench for serv_ext_sched.
// dut_a uses the default parameters (TIMEOUT=64).
// dut_b uses TIMEOUT=8 with MDU masked.
// Only one DUT runs at a time; the other is held in reset.
module tb_serv_ext_sched;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        mdu_req, ava_req, mdu_ready, ava_ready, cnt_en;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, mdu_rd, ava_rd;

    logic        a_mv, a_av, a_rdy, a_rd, a_busy, a_tmo;
    logic [2:0]  a_f3;
    logic [31:0] a_rs1, a_rs2;
    logic        b_mv, b_av, b_rdy, b_rd, b_busy, b_tmo;
    logic [2:0]  b_f3;
    logic [31:0] b_rs1, b_rs2;

    bit          use_b = 1'b0;
    logic        mv, av, rdy, rd, busy, tmo;
    logic [2:0]  ef3;
    logic [31:0] ers1, ers2;

    int          errors = 0;
    int          checks = 0;
    int          ready_seen = 0;
    bit          pref_ava [2];      // model: unit that wins the next tie, per DUT

    always #5 clk = ~clk;

    serv_ext_sched dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_mdu_req(mdu_req), .i_ava_req(ava_req),
        .i_funct3(funct3), .i_rs1(rs1), .i_rs2(rs2),
        .o_mdu_valid(a_mv), .o_ava_valid(a_av), .o_ext_funct3(a_f3),
        .o_ext_rs1(a_rs1), .o_ext_rs2(a_rs2),
        .i_mdu_ready(mdu_ready), .i_mdu_rd(mdu_rd), .i_ava_ready(ava_ready), .i_ava_rd(ava_rd),
        .o_ready(a_rdy), .i_cnt_en(cnt_en), .o_rd(a_rd), .o_busy(a_busy), .o_timeout(a_tmo)
    );

    serv_ext_sched #(.MDU(0), .TIMEOUT(8)) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_mdu_req(mdu_req), .i_ava_req(ava_req),
        .i_funct3(funct3), .i_rs1(rs1), .i_rs2(rs2),
        .o_mdu_valid(b_mv), .o_ava_valid(b_av), .o_ext_funct3(b_f3),
        .o_ext_rs1(b_rs1), .o_ext_rs2(b_rs2),
        .i_mdu_ready(mdu_ready), .i_mdu_rd(mdu_rd), .i_ava_ready(ava_ready), .i_ava_rd(ava_rd),
        .o_ready(b_rdy), .i_cnt_en(cnt_en), .o_rd(b_rd), .o_busy(b_busy), .o_timeout(b_tmo)
    );

    assign mv   = use_b ? b_mv   : a_mv;
    assign av   = use_b ? b_av   : a_av;
    assign rdy  = use_b ? b_rdy  : a_rdy;
    assign rd   = use_b ? b_rd   : a_rd;
    assign busy = use_b ? b_busy : a_busy;
    assign tmo  = use_b ? b_tmo  : a_tmo;
    assign ef3  = use_b ? b_f3   : a_f3;
    assign ers1 = use_b ? b_rs1  : a_rs1;
    assign ers2 = use_b ? b_rs2  : a_rs2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Count o_ready pulses and watch that both valids are never high together.
    always @(negedge clk) begin
        if (rdy === 1'b1) ready_seen++;
        if (mv === 1'b1 || av === 1'b1) check("valid_overlap", {31'd0, mv & av}, 32'd0);
    end

    task automatic set_rst(input bit v);
        if (use_b) rst_b = v;
        else       rst_a = v;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, {26'd0, mv, av, rdy, rd, busy, tmo}, 32'd0);
        check({tag, "_f3"},  {29'd0, ef3}, 32'd0);
        check({tag, "_rs1"}, ers1, 32'd0);
        check({tag, "_rs2"}, ers2, 32'd0);
    endtask

    // Reset in mid-operation: the next cycle must show all outputs at 0 and no o_ready pulse.
    task automatic reset_now(input string tag, input int rdy_before);
        set_rst(1'b1);
        mdu_req = 1'b0; ava_req = 1'b0; cnt_en = 1'b0; mdu_ready = 1'b0; ava_ready = 1'b0;
        @(negedge clk);
        check_zero(tag);
        set_rst(1'b0);
        pref_ava[use_b] = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_no_ready"}, ready_seen - rdy_before, 32'd0);
    endtask

    // One full transaction, checked against the model.
    // lat is the WAIT cycle (1-based) in which the granted unit raises ready.
    // rst_shift > 0 resets the DUT after that many result bits have been shifted out.
    task automatic run_op(input bit rm, input bit ra, input logic [2:0] f3,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input int lat, input logic [31:0] rdv, input int rst_shift);
        bit          em, ea, g_ava, exp_to;
        int          to_lim, wend, rdy0, nb, budget;
        logic [31:0] exp_res, got;
        em      = rm && !use_b;
        ea      = ra;
        g_ava   = ea && (!em || pref_ava[use_b]);
        pref_ava[use_b] = !g_ava;
        to_lim  = use_b ? 8 : 64;
        exp_to  = lat > to_lim;
        exp_res = exp_to ? 32'd0 : rdv;
        wend    = exp_to ? to_lim : lat;
        rdy0    = ready_seen;

        @(negedge clk);
        mdu_req = rm; ava_req = ra; funct3 = f3; rs1 = r1; rs2 = r2;
        for (int w = 1; w <= wend; w++) begin
            @(negedge clk);
            if (w == 1) begin
                check("grant_busy", {31'd0, busy}, 32'd1);
                check("grant_tmo_clr", {31'd0, tmo}, 32'd0);
                check("ext_f3", {29'd0, ef3}, {29'd0, f3});
                check("ext_rs1", ers1, r1);
                check("ext_rs2", ers2, r2);
            end
            check("mdu_valid", {31'd0, mv}, {31'd0, !g_ava});
            check("ava_valid", {31'd0, av}, {31'd0, g_ava});
            check("ready_early", {31'd0, rdy}, 32'd0);
            mdu_ready = (w == lat) && !g_ava;
            ava_ready = (w == lat) &&  g_ava;
            mdu_rd    = g_ava ? $urandom : rdv;
            ava_rd    = g_ava ? rdv : $urandom;
            if ($urandom_range(0, 3) == 0) begin
                if (g_ava) mdu_ready = 1'b1;
                else       ava_ready = 1'b1;
            end
        end

        @(negedge clk);
        mdu_ready = 1'b0; ava_ready = 1'b0;
        check("resp_ready", {31'd0, rdy}, 32'd1);
        check("resp_valids", {30'd0, mv, av}, 32'd0);
        check("resp_tmo", {31'd0, tmo}, {31'd0, exp_to});
        check("resp_rd", {31'd0, rd}, 32'd0);
        mdu_req = 1'b0; ava_req = 1'b0;

        nb = 0; got = 32'd0; budget = 0;
        while (nb < 32 && budget < 400) begin
            @(negedge clk);
            budget++;
            if (rst_shift > 0 && nb == rst_shift) begin
                reset_now("rst_drain", ready_seen);
                return;
            end
            cnt_en = ($urandom_range(0, 3) != 0);
            if (cnt_en) begin
                got[nb] = rd;
                nb++;
            end
        end
        check("drain_budget", nb, 32'd32);
        check("serial_result", got, exp_res);

        @(negedge clk);
        cnt_en = 1'b0;
        check("drained_rd", {31'd0, rd}, 32'd0);
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("ready_once", ready_seen - rdy0, 32'd1);
        check("idle_tmo", {31'd0, tmo}, {31'd0, exp_to});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rdy0;
        bit rm, ra;
        int lat;
        rst_a = 1'b1; rst_b = 1'b1;
        mdu_req = 1'b0; ava_req = 1'b0; mdu_ready = 1'b0; ava_ready = 1'b0; cnt_en = 1'b0;
        funct3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0; mdu_rd = 32'd0; ava_rd = 32'd0;
        pref_ava[0] = 1'b0; pref_ava[1] = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset_a");
        rst_a = 1'b0;

        // MUL 3*5, unit answers in WAIT cycle 10.
        run_op(1'b1, 1'b0, 3'b000, 32'd3, 32'd5, 10, 32'd15, 0);

        // Both requests after reset: MDU first, then AVA.
        rst_a = 1'b1; @(negedge clk); rst_a = 1'b0; pref_ava[0] = 1'b0;
        run_op(1'b1, 1'b1, 3'b001, 32'h1234, 32'h5678, 2, 32'hA5A5_0001, 0);
        run_op(1'b1, 1'b1, 3'b010, 32'h9abc, 32'hdef0, 1, 32'h0000_8003, 0);

        // Request withdrawn in WAIT: silent abort, no o_ready, no timeout.
        rdy0 = ready_seen;
        @(negedge clk); ava_req = 1'b1; pref_ava[0] = 1'b0;
        @(negedge clk); check("abort_valid", {31'd0, av}, 32'd1);
        @(negedge clk); ava_req = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy | av | rdy}, 32'd0);
        check("abort_tmo", {31'd0, tmo}, 32'd0);
        check("abort_no_ready", ready_seen - rdy0, 32'd0);

        // Reset during WAIT.
        rdy0 = ready_seen;
        @(negedge clk); mdu_req = 1'b1; funct3 = 3'd5; rs1 = 32'hFFFF_0000; rs2 = 32'h0F0F_0F0F;
        repeat (3) @(negedge clk);
        check("pre_rst_valid", {31'd0, mv}, 32'd1);
        reset_now("rst_wait", rdy0);

        // Reset in DRAIN after 17 shifts.
        run_op(1'b1, 1'b0, 3'd3, 32'h1111, 32'h2222, 3, 32'hFFFF_FFFF, 17);

        for (int i = 0; i < 16; i++) begin
            do begin
                rm = 1'($urandom_range(0, 1));
                ra = 1'($urandom_range(0, 1));
            end while (!(rm || ra));
            lat = ($urandom_range(0, 7) == 0) ? 70 : $urandom_range(1, 12);
            run_op(rm, ra, 3'($urandom), $urandom, $urandom, lat, $urandom, 0);
        end

        // Switch to dut_b: TIMEOUT=8 with MDU masked.
        rst_a = 1'b1; use_b = 1'b1;
        @(negedge clk);
        check_zero("reset_b");
        rst_b = 1'b0;

        // A masked MDU request is never granted, and a stray MDU ready is ignored.
        mdu_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mdu_ready = (i == 5);
            mdu_rd    = 32'hBAD0_0000;
            @(negedge clk);
            check("masked_idle", {30'd0, busy, mv}, 32'd0);
        end
        mdu_req = 1'b0; mdu_ready = 1'b0;

        // Unit never ready: expiry in WAIT cycle 8 and an all-zero result.
        run_op(1'b0, 1'b1, 3'd4, 32'h7, 32'h9, 1000, 32'hFFFF_FFFF, 0);
        repeat (3) begin
            @(negedge clk);
            check("tmo_sticky", {31'd0, tmo}, 32'd1);
        end

        // Ready arrives in the same cycle as expiry: ready wins.
        run_op(1'b0, 1'b1, 3'd6, 32'h1, 32'h2, 8, 32'hDEAD_BEEF, 0);

        for (int i = 0; i < 10; i++) begin
            run_op(1'($urandom_range(0, 1)), 1'b1, 3'($urandom), $urandom, $urandom,
                   $urandom_range(1, 12), $urandom, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
